// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and data memory.
// The master side issues requests; the slave side returns read data and the completion pulse.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: EX/MEM register, branch resolve, and variable-latency dmem access.
// Drives the MEM/WB register with lane-extended load data, writeback controls and an exception flag.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  dCtrl,
  input  logic [1:0]  dDsize,
  input  logic [31:0] dALUout,
  input  logic [31:0] dBusB,
  input  logic [4:0]  dRw,
  input  logic [31:0] dBranchTarget,
  input  logic [31:0] dNextAddress,
  mem_stage_if.master dmem,
  output logic        stall,
  output logic        PCSrc,
  output logic [31:0] BranchTarget,
  output logic        MemtoReg,
  output logic        RegWr,
  output logic [31:0] ALUout,
  output logic [31:0] MemData,
  output logic [4:0]  Rw,
  output logic        Exc
);
  // state    | meaning
  // IDLE     | EX/MEM op evaluated; a legal memory op starts an access
  // ACCESS   | request held on the bus until ack or timeout
  // COMPLETE | result ready; both pipeline registers advance
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCESS   = 2'd1,
    S_COMPLETE = 2'd2
  } state_t;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  state_t      r_state, w_next;
  logic [6:0]  r_ctrl;
  logic [1:0]  r_dsize;
  logic [31:0] r_alu, r_busb, r_bt, r_na;
  logic [4:0]  r_rw;
  logic [7:0]  r_cnt;
  logic [31:0] r_data;
  logic        r_timeout;
  logic        r_wb_regwr, r_wb_m2r, r_wb_exc;
  logic [31:0] r_wb_alu, r_wb_data;
  logic [4:0]  r_wb_rw;

  logic        w_mem_op, w_bad, w_limit;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl  <= '0;
      r_dsize <= '0;
      r_alu   <= '0;
      r_busb  <= '0;
      r_rw    <= '0;
      r_bt    <= '0;
      r_na    <= '0;
    end else if (!stall) begin
      r_ctrl  <= dCtrl;
      r_dsize <= dDsize;
      r_alu   <= dALUout;
      r_busb  <= dBusB;
      r_rw    <= dRw;
      r_bt    <= dBranchTarget;
      r_na    <= dNextAddress;
    end
  end

  assign w_mem_op = r_ctrl[6] | r_ctrl[5];
  assign w_off    = r_alu[1:0];
  assign w_bad    = w_mem_op & ((r_dsize == 2'b11) |
                                ((r_dsize == 2'b01) & w_off[0]) |
                                ((r_dsize == 2'b00) & (w_off != 2'b00)));
  assign w_limit  = (r_cnt == LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_op & ~w_bad) begin
          stall  = 1'b1;
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        stall = 1'b1;
        if (dmem.dmem_ack | w_limit) w_next = S_COMPLETE;
      end
      S_COMPLETE: w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Ack wins over the limit when both land in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_data    <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_ACCESS: begin
          r_cnt <= r_cnt + 8'd1;
          if (dmem.dmem_ack) begin
            r_data    <= w_ext;
            r_timeout <= 1'b0;
          end else if (w_limit) begin
            r_data    <= '0;
            r_timeout <= 1'b1;
          end
        end
        S_COMPLETE: begin
          r_cnt     <= '0;
          r_timeout <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Big-endian lanes: offset 0 is bits 31:24
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_busb;
    case (r_dsize)
      2'b10: begin
        w_be    = 4'b1000 >> w_off;
        w_wdata = {4{r_busb[7:0]}};
      end
      2'b01: begin
        w_be    = w_off[1] ? 4'b0011 : 4'b1100;
        w_wdata = {2{r_busb[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = 8'(dmem.dmem_rdata >> {~w_off, 3'b000});
    w_half = w_off[1] ? dmem.dmem_rdata[15:0] : dmem.dmem_rdata[31:16];
    case (r_dsize)
      2'b10:   w_ext = {{24{r_ctrl[0] & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{r_ctrl[0] & w_half[15]}}, w_half};
      default: w_ext = dmem.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_regwr <= 1'b0;
      r_wb_m2r   <= 1'b0;
      r_wb_alu   <= '0;
      r_wb_data  <= '0;
      r_wb_rw    <= '0;
      r_wb_exc   <= 1'b0;
    end else if (!stall) begin
      r_wb_regwr <= r_ctrl[4] & ~w_bad & ~r_timeout;
      r_wb_m2r   <= r_ctrl[5];
      r_wb_alu   <= r_ctrl[1] ? r_na : r_alu;
      r_wb_data  <= r_data;
      r_wb_rw    <= r_rw;
      r_wb_exc   <= w_bad | r_timeout;
    end
  end

  assign dmem.dmem_req   = (r_state == S_ACCESS);
  assign dmem.dmem_we    = r_ctrl[6];
  assign dmem.dmem_addr  = {r_alu[31:2], 2'b00};
  assign dmem.dmem_be    = w_be;
  assign dmem.dmem_wdata = w_wdata;

  assign PCSrc        = r_ctrl[3] & r_ctrl[2];
  assign BranchTarget = r_bt;
  assign MemtoReg     = r_wb_m2r;
  assign RegWr        = r_wb_regwr;
  assign ALUout       = r_wb_alu;
  assign MemData      = r_wb_data;
  assign Rw           = r_wb_rw;
  assign Exc          = r_wb_exc;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: hand-computed vector table, reset-in-flight sequence,
// then randomized instructions checked against a byte-lane reference model.
module tb_mem_stage;
  localparam int TO = 4;

  typedef struct packed {
    logic [6:0]  ctrl;
    logic [1:0]  dsize;
    logic [31:0] alu, busb;
    logic [4:0]  rw;
    logic [31:0] bt, na;
    logic [7:0]  dly;
    logic [31:0] rdata;
  } instr_t;

  typedef struct packed {
    logic        pcsrc;
    logic [31:0] bt;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [7:0]  req_cyc, stall_cyc;
    logic        regwr, m2r;
    logic [31:0] aluout, memdata;
    logic [4:0]  rw;
    logic        exc;
  } result_t;

  typedef struct packed {
    instr_t  i;
    result_t e;
  } vec_t;

  logic clk = 1'b0, reset = 1'b1;
  logic [6:0]  dCtrl = '0;
  logic [1:0]  dDsize = '0;
  logic [31:0] dALUout = '0, dBusB = '0, dBranchTarget = '0, dNextAddress = '0;
  logic [4:0]  dRw = '0;
  logic        stall, PCSrc, MemtoReg, RegWr, Exc;
  logic [31:0] BranchTarget, ALUout, MemData;
  logic [4:0]  Rw;

  int n_pass = 0, n_total = 0;
  logic [31:0] m_held = '0;

  mem_stage_if dmem ();

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .dCtrl(dCtrl), .dDsize(dDsize), .dALUout(dALUout), .dBusB(dBusB), .dRw(dRw),
    .dBranchTarget(dBranchTarget), .dNextAddress(dNextAddress),
    .dmem(dmem),
    .stall(stall), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
    .MemtoReg(MemtoReg), .RegWr(RegWr), .ALUout(ALUout), .MemData(MemData),
    .Rw(Rw), .Exc(Exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] ext_model(input logic [31:0] rd, input logic [1:0] sz,
                                            input int o, input logic sx);
    int unsigned v, w;
    if (sz == 2'd2) begin
      v = (rd >> (24 - 8 * o)) & 32'hFF; w = 8;
    end else if (sz == 2'd1) begin
      v = (o == 0) ? (rd >> 16) : (rd & 32'hFFFF); w = 16;
    end else return rd;
    if (sx && v >= (32'd1 << (w - 1))) v = v - (32'd1 << w);
    return v;
  endfunction

  // Reference: access size in bytes, alignment as "offset multiple of size", lanes by byte index
  function automatic result_t model(input instr_t i, input logic [31:0] held_in,
                                    output logic [31:0] held_out);
    result_t e;
    int o, nb, req;
    logic mem_op, bad, acc, to;
    e = '0;
    o = int'(i.alu[1:0]);
    nb = (i.dsize == 2'd2) ? 1 : (i.dsize == 2'd1) ? 2 : 4;
    mem_op = i.ctrl[6] | i.ctrl[5];
    bad = mem_op && (i.dsize == 2'd3 || (o % nb) != 0);
    acc = mem_op && !bad;
    to = acc && (i.dly == 0 || int'(i.dly) > TO);
    held_out = held_in;
    if (acc) held_out = to ? 32'h0 : ext_model(i.rdata, i.dsize, o, i.ctrl[0]);
    e.pcsrc = i.ctrl[3] & i.ctrl[2];
    e.bt = i.bt;
    e.we = i.ctrl[6];
    e.addr = i.alu - 32'(o);
    for (int k = 0; k < 4; k++) begin
      e.be[3-k] = (k >= o) && (k < o + nb);
      e.wdata[31-8*k -: 8] = 8'(i.busb >> (8 * ((nb - 1) - (k % nb))));
    end
    req = acc ? (to ? TO : int'(i.dly)) : 0;
    e.req_cyc = 8'(req);
    e.stall_cyc = acc ? 8'(req + 1) : 8'd0;
    e.regwr = i.ctrl[4] && !bad && !to;
    e.m2r = i.ctrl[5];
    e.aluout = i.ctrl[1] ? i.na : i.alu;
    e.memdata = held_out;
    e.rw = i.rw;
    e.exc = bad || to;
    return e;
  endfunction

  // Presents one instruction, plays the memory, and returns what the DUT did
  task automatic run_instr(input instr_t i, input string tag, output result_t r);
    logic done;
    r = '0;
    done = 1'b0;
    dCtrl = i.ctrl; dDsize = i.dsize; dALUout = i.alu; dBusB = i.busb;
    dRw = i.rw; dBranchTarget = i.bt; dNextAddress = i.na;
    @(posedge clk); #1;
    dCtrl = '0; dDsize = 2'($urandom); dALUout = $urandom; dBusB = $urandom;
    dRw = 5'($urandom); dBranchTarget = $urandom; dNextAddress = $urandom;
    r.pcsrc = PCSrc;
    r.bt = BranchTarget;
    for (int n = 0; n < 40; n++) begin
      if (!stall) begin
        @(posedge clk); #1;
        done = 1'b1;
        break;
      end
      r.stall_cyc = r.stall_cyc + 8'd1;
      if (dmem.dmem_req) begin
        r.req_cyc = r.req_cyc + 8'd1;
        if (r.req_cyc == 8'd1) begin
          r.we = dmem.dmem_we; r.addr = dmem.dmem_addr;
          r.be = dmem.dmem_be; r.wdata = dmem.dmem_wdata;
        end
        if (r.req_cyc == i.dly) begin
          dmem.dmem_ack = 1'b1;
          dmem.dmem_rdata = i.rdata;
        end
      end
      @(posedge clk); #1;
      dmem.dmem_ack = 1'b0;
      dmem.dmem_rdata = $urandom;
    end
    if (!done) begin
      n_total++;
      $display("FAIL %s budget: stall still high after 40 cycles", tag);
    end
    r.regwr = RegWr; r.m2r = MemtoReg; r.aluout = ALUout;
    r.memdata = MemData; r.rw = Rw; r.exc = Exc;
  endtask

  task automatic compare(input string tag, input result_t g, input result_t e);
    chk({tag, " pcsrc"}, 32'(g.pcsrc), 32'(e.pcsrc));
    chk({tag, " bt"}, g.bt, e.bt);
    chk({tag, " stall_cyc"}, 32'(g.stall_cyc), 32'(e.stall_cyc));
    chk({tag, " req_cyc"}, 32'(g.req_cyc), 32'(e.req_cyc));
    chk({tag, " regwr"}, 32'(g.regwr), 32'(e.regwr));
    chk({tag, " m2r"}, 32'(g.m2r), 32'(e.m2r));
    chk({tag, " aluout"}, g.aluout, e.aluout);
    chk({tag, " memdata"}, g.memdata, e.memdata);
    chk({tag, " rw"}, 32'(g.rw), 32'(e.rw));
    chk({tag, " exc"}, 32'(g.exc), 32'(e.exc));
    if (e.req_cyc != 0) begin
      chk({tag, " we"}, 32'(g.we), 32'(e.we));
      chk({tag, " addr"}, g.addr, e.addr);
      chk({tag, " be"}, 32'(g.be), 32'(e.be));
      if (e.we) chk({tag, " wdata"}, g.wdata, e.wdata);
    end
  endtask

  function automatic vec_t mkv(input logic [6:0] c, input logic [1:0] sz,
                               input logic [31:0] alu, busb, input logic [4:0] rw,
                               input logic [31:0] bt, na, input int dly, input logic [31:0] rd,
                               input logic pcs, regwr, exc, input logic [31:0] aluo, memd,
                               input logic [3:0] be, input logic [31:0] wd, input int stl, req);
    vec_t v;
    v.i = '{ctrl: c, dsize: sz, alu: alu, busb: busb, rw: rw, bt: bt, na: na,
            dly: 8'(dly), rdata: rd};
    v.e = '{pcsrc: pcs, bt: bt, we: c[6], addr: {alu[31:2], 2'b00}, be: be, wdata: wd,
            req_cyc: 8'(req), stall_cyc: 8'(stl), regwr: regwr, m2r: c[5],
            aluout: aluo, memdata: memd, rw: rw, exc: exc};
    return v;
  endfunction

  initial begin
    vec_t    tbl [12];
    result_t got, exp;
    instr_t  ri;
    string   tag;

    // ctrl = {MemWr, MemtoReg, RegWr, Branch, Zero, Jal, Loadext}
    tbl[0]  = mkv(7'b0010000, 2'd0, 32'h1234, 32'h0, 5'd5, 32'h10, 32'h0, 0, 32'h0,
                  1'b0, 1'b1, 1'b0, 32'h1234, 32'h0, 4'h0, 32'h0, 0, 0);
    tbl[1]  = mkv(7'b0110001, 2'd2, 32'h101, 32'h0, 5'd7, 32'h14, 32'h0, 3, 32'h11F23344,
                  1'b0, 1'b1, 1'b0, 32'h101, 32'hFFFFFFF2, 4'b0100, 32'h0, 4, 3);
    tbl[2]  = mkv(7'b1000000, 2'd1, 32'h202, 32'hABCD1234, 5'd3, 32'h18, 32'h0, 1, 32'h0,
                  1'b0, 1'b0, 1'b0, 32'h202, 32'h0, 4'b0011, 32'h12341234, 2, 1);
    tbl[3]  = mkv(7'b0110000, 2'd0, 32'h103, 32'h0, 5'd9, 32'h1C, 32'h0, 1, 32'h0,
                  1'b0, 1'b0, 1'b1, 32'h103, 32'h0, 4'h0, 32'h0, 0, 0);
    tbl[4]  = mkv(7'b0110000, 2'd0, 32'h300, 32'h0, 5'd10, 32'h20, 32'h0, 0, 32'hDEADBEEF,
                  1'b0, 1'b0, 1'b1, 32'h300, 32'h0, 4'b1111, 32'h0, 5, 4);
    tbl[5]  = mkv(7'b0001100, 2'd0, 32'h0, 32'h0, 5'd0, 32'h40, 32'h0, 0, 32'h0,
                  1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 0, 0);
    tbl[6]  = mkv(7'b0010010, 2'd0, 32'h5555, 32'h0, 5'd31, 32'h24, 32'h88, 0, 32'h0,
                  1'b0, 1'b1, 1'b0, 32'h88, 32'h0, 4'h0, 32'h0, 0, 0);
    tbl[7]  = mkv(7'b0110000, 2'd1, 32'h404, 32'h0, 5'd11, 32'h28, 32'h0, 1, 32'h87654321,
                  1'b0, 1'b1, 1'b0, 32'h404, 32'h00008765, 4'b1100, 32'h0, 2, 1);
    tbl[8]  = mkv(7'b0110000, 2'd0, 32'h500, 32'h0, 5'd12, 32'h2C, 32'h0, 4, 32'hCAFEBABE,
                  1'b0, 1'b1, 1'b0, 32'h500, 32'hCAFEBABE, 4'b1111, 32'h0, 5, 4);
    tbl[9]  = mkv(7'b0110000, 2'd3, 32'h600, 32'h0, 5'd13, 32'h30, 32'h0, 1, 32'h0,
                  1'b0, 1'b0, 1'b1, 32'h600, 32'hCAFEBABE, 4'h0, 32'h0, 0, 0);
    tbl[10] = mkv(7'b1000000, 2'd2, 32'h703, 32'h000000A5, 5'd14, 32'h34, 32'h0, 2, 32'h0,
                  1'b0, 1'b0, 1'b0, 32'h703, 32'h0, 4'b0001, 32'hA5A5A5A5, 3, 2);
    tbl[11] = mkv(7'b0110000, 2'd2, 32'h803, 32'h0, 5'd15, 32'h38, 32'h0, 1, 32'h123456F0,
                  1'b0, 1'b1, 1'b0, 32'h803, 32'h000000F0, 4'b0001, 32'h0, 2, 1);

    dmem.dmem_ack = 1'b0;
    dmem.dmem_rdata = '0;

    #3;
    chk("rst stall", 32'(stall), 32'h0);
    chk("rst req", 32'(dmem.dmem_req), 32'h0);
    chk("rst regwr", 32'(RegWr), 32'h0);
    chk("rst aluout", ALUout, 32'h0);
    chk("rst memdata", MemData, 32'h0);
    chk("rst exc", 32'(Exc), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[k]) begin
      tag = $sformatf("vec%0d", k);
      run_instr(tbl[k].i, tag, got);
      compare(tag, got, tbl[k].e);
      exp = model(tbl[k].i, m_held, m_held);
    end

    // Reset landing mid-access, with an ack arriving during reset
    dCtrl = 7'b0110000; dDsize = 2'd0; dALUout = 32'h900; dRw = 5'd20;
    @(posedge clk); #1;
    dCtrl = '0;
    @(posedge clk); #1;
    chk("inflight req", 32'(dmem.dmem_req), 32'h1);
    #2;
    reset = 1'b1;
    dmem.dmem_ack = 1'b1;
    dmem.dmem_rdata = 32'hFFFFFFFF;
    #1;
    chk("midrst req", 32'(dmem.dmem_req), 32'h0);
    chk("midrst stall", 32'(stall), 32'h0);
    chk("midrst regwr", 32'(RegWr), 32'h0);
    chk("midrst memdata", MemData, 32'h0);
    chk("midrst rw", 32'(Rw), 32'h0);
    chk("midrst addr", dmem.dmem_addr, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    dmem.dmem_ack = 1'b0;
    @(posedge clk); #1;
    chk("postrst stall", 32'(stall), 32'h0);
    chk("postrst req", 32'(dmem.dmem_req), 32'h0);
    @(posedge clk); #1;
    chk("postrst memdata", MemData, 32'h0);
    chk("postrst regwr", 32'(RegWr), 32'h0);
    m_held = '0;

    for (int n = 0; n < 60; n++) begin
      ri.ctrl = 7'($urandom);
      ri.dsize = 2'($urandom);
      ri.alu = $urandom;
      ri.busb = $urandom;
      ri.rw = 5'($urandom);
      ri.bt = $urandom;
      ri.na = $urandom;
      ri.dly = 8'($urandom_range(0, 6));
      ri.rdata = $urandom;
      tag = $sformatf("rnd%0d", n);
      exp = model(ri, m_held, m_held);
      run_instr(ri, tag, got);
      compare(tag, got, exp);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory stage of the 5-stage pipeline, directly downstream of the execute stage. It holds the EX/MEM pipeline register and resolves branches. It runs loads and stores against a variable-latency data memory through a req/ack handshake, stalling the pipeline while an access is in flight. It also drives the MEM/WB pipeline register with extended load data and the writeback controls.

Parameters:
TIMEOUT, 16, max ACCESS cycles without dmem_ack before abandoning the access (range 2..255)

Ports:
clk  in  1  pipeline clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
dCtrl  in  7  from execute: {MemWr, MemtoReg, RegWr, Branch, Zero, Jal, Loadext}, bit 6 = MemWr
dDsize  in  2  access size: 00 word, 01 halfword, 10 byte, 11 illegal
dALUout  in  32  ALU result; byte address for memory ops
dBusB  in  32  store data
dRw  in  5  destination register
dBranchTarget  in  32  computed branch target
dNextAddress  in  32  PC+4 link value for Jal
dmem_req  out  1  registered; high for the whole access
dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
dmem_addr  out  32  {ALUout[31:2], 2'b00}
dmem_be  out  4  byte enables, bit 3 = bits 31:24
dmem_wdata  out  32  lane-replicated store data
dmem_rdata  in  32  load data, valid when dmem_ack
dmem_ack  in  1  one-cycle completion pulse
stall  out  1  combinational; freezes PC, IF/ID, ID/EX, EX/MEM
PCSrc  out  1  combinational qBranch & qZero from EX/MEM
BranchTarget  out  32  EX/MEM branch target
MemtoReg  out  1  MEM/WB: select MemData
RegWr  out  1  MEM/WB: register write enable
ALUout  out  32  MEM/WB: ALU result, or NextAddress when Jal
MemData  out  32  MEM/WB: extended load data
Rw  out  5  MEM/WB destination register
Exc  out  1  MEM/WB: misaligned, illegal size, or timeout

Behaviour:
- Reset: all outputs, both pipeline registers, FSM (IDLE), timeout counter and data holding register go to 0, asynchronously. A reset mid-ACCESS drops dmem_req at once. A dmem_ack arriving during or after reset is ignored.
- EX/MEM register loads d* at posedge when stall=0 and holds when stall=1. mem_op = qMemWr | qMemtoReg.
- bad = mem_op & (Dsize=11 | (Dsize=01 & addr[0]) | (Dsize=00 & addr[1:0]!=0)). A bad instruction issues no access and raises no stall. It passes in one cycle with RegWr=0 and Exc=1.
- FSM IDLE: if mem_op & ~bad, go to ACCESS, stall=1; otherwise stall=0.
- FSM ACCESS: dmem_req=1 and stall=1. The counter increments each cycle.
  - On dmem_ack: capture the extended rdata, go to COMPLETE.
  - When the counter reaches TIMEOUT-1 with no ack: set the timeout flag, data=0, go to COMPLETE.
  - An ack in the same cycle the limit is hit counts as success.
- FSM COMPLETE: stall=0 and dmem_req=0. Both pipeline registers advance. The counter clears. Next state is IDLE.
- Minimum memory-op occupancy is 3 cycles (IDLE, ACCESS, COMPLETE). A non-memory op takes 1 cycle.
- MEM/WB register loads at posedge when stall=0:
  - RegWr = qRegWr & ~bad & ~timeout
  - MemtoReg = qMemtoReg
  - ALUout = qJal ? qNextAddress : qALUout
  - MemData = held data
  - Rw = qRw
  - Exc = bad | timeout
  - While stall=1, MEM/WB holds its value.
- Byte lanes are big-endian. Let o = addr[1:0].
  - Byte: be = 4'b1000 >> o, wdata = {4{B[7:0]}}.
  - Half: be = 1100 when o=0, 0011 when o=2; wdata = {2{B[15:0]}}.
  - Word: be = 1111, wdata = B.
- Loads select the lane by the same mapping. Loadext=1 sign-extends; Loadext=0 zero-extends. A word load is unchanged.
- PCSrc and BranchTarget come combinationally from EX/MEM and are valid in every state. Upstream flush is not this block's job.

Test Plan:
- ALU op: dCtrl RegWr=1, dALUout=0x1234, dRw=5 -> after 2 edges RegWr=1, ALUout=0x1234, Rw=5; stall never high.
- Byte load, sign-extend: addr 0x101, Loadext=1, memory acks after 3 cycles with rdata 0x11F23344 -> dmem_be=0100, stall high 4 cycles, MemData=0xFFFFFFF2.
- Halfword store: addr 0x202, B=0xABCD1234 -> dmem_we=1, addr 0x200, be=0011, wdata=0x12341234; RegWr=0.
- Misaligned word load at 0x103 -> no dmem_req, no stall, RegWr=0, Exc=1.
- Timeout: TIMEOUT=4, load with no ack -> dmem_req high exactly 4 cycles, then Exc=1, RegWr=0, MemData=0. Reset asserted during ACCESS -> dmem_req and stall 0 immediately, outputs 0.
- Branch: Branch=1, Zero=1, target 0x40 -> PCSrc=1, BranchTarget=0x40 the cycle after capture. Jal with NextAddress 0x88, Rw=31 -> ALUout=0x88, RegWr=1.
